// File: rtl/nibble_packer.sv
// Packs consecutive 4-bit nibbles into a NIBBLES*4-bit word behind a valid/ready handshake.
// A flush closes a partial word early and pads the unfilled slots with PAD_NIBBLE.
module nibble_packer #(
  parameter int          NIBBLES    = 4,
  parameter logic [3:0]  PAD_NIBBLE = 4'h9,
  localparam int         CW         = $clog2(NIBBLES + 1),
  localparam int         WW         = NIBBLES * 4
) (
  input  logic          ck,
  input  logic          arst,
  input  logic [3:0]    inVal,
  input  logic          inValid,
  output logic          inReady,
  input  logic          flush,
  output logic [WW-1:0] outWord,
  output logic          outValid,
  input  logic          outReady,
  output logic [CW-1:0] outCount,
  output logic [7:0]    outSeq
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state_q;
  logic [CW-1:0] idx_q;
  logic [WW-1:0] slots_q;
  logic [WW-1:0] word_q;
  logic [CW-1:0] count_q;
  logic [7:0]    seq_q;

  logic          accept;
  logic          pop;
  logic [CW-1:0] fill_d;
  logic [CW-1:0] wr_idx_d;
  logic          full_d;

  // Slots below n_old come from the partial buffer, slot n_old takes the
  // incoming nibble when one is accepted this cycle, the rest are padding.
  function automatic logic [WW-1:0] assemble(input logic [WW-1:0] part,
                                             input logic [CW-1:0] n_old,
                                             input logic          take,
                                             input logic [3:0]    nib);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (k < int'(n_old))
        w[4*k +: 4] = part[4*k +: 4];
      else if ((k == int'(n_old)) && take)
        w[4*k +: 4] = nib;
      else
        w[4*k +: 4] = PAD_NIBBLE;
    end
    return w;
  endfunction

  always_comb begin
    inReady  = (state_q == FILL) | outReady;
    accept   = inValid & inReady;
    pop      = (state_q == HOLD) & outReady;
    fill_d   = idx_q + CW'(accept);
    full_d   = accept & (idx_q == CW'(NIBBLES - 1));
    wr_idx_d = (state_q == HOLD) ? '0 : idx_q;
  end

  assign outValid = (state_q == HOLD);
  assign outWord  = word_q;
  assign outCount = count_q;
  assign outSeq   = seq_q;

  // Partial-word storage is pure data: it is always rewritten from slot 0 after reset.
  always_ff @(posedge ck) begin
    if (accept)
      slots_q[int'(wr_idx_d)*4 +: 4] <= inVal;
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_q <= FILL;
      idx_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (full_d || (flush && (fill_d != '0))) begin
            word_q  <= assemble(slots_q, idx_q, accept, inVal);
            count_q <= fill_d;
            idx_q   <= '0;
            state_q <= HOLD;
          end else if (accept) begin
            idx_q <= idx_q + CW'(1);
          end
        end
        HOLD: begin
          if (pop) begin
            seq_q <= seq_q + 8'd1;
            if (accept && flush) begin
              // Released word is immediately replaced by a one-nibble padded word.
              word_q  <= assemble(slots_q, '0, 1'b1, inVal);
              count_q <= CW'(1);
              idx_q   <= '0;
            end else if (accept) begin
              idx_q   <= CW'(1);
              state_q <= FILL;
            end else begin
              idx_q   <= '0;
              state_q <= FILL;
            end
          end
        end
        default: begin
          state_q <= FILL;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: directed scenarios plus random traffic against a queue-based model.
module tb_nibble_packer;
  localparam int         N   = 4;
  localparam int         CW  = $clog2(N + 1);
  localparam logic [3:0] PAD = 4'h9;

  logic          ck = 1'b0;
  logic          arst;
  logic [3:0]    inVal;
  logic          inValid;
  logic          inReady;
  logic          flush;
  logic [N*4-1:0] outWord;
  logic          outValid;
  logic          outReady;
  logic [CW-1:0] outCount;
  logic [7:0]    outSeq;

  nibble_packer #(.NIBBLES(N), .PAD_NIBBLE(PAD)) dut (
    .ck(ck), .arst(arst), .inVal(inVal), .inValid(inValid), .inReady(inReady),
    .flush(flush), .outWord(outWord), .outValid(outValid), .outReady(outReady),
    .outCount(outCount), .outSeq(outSeq)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received-but-unpacked nibbles, plus the word on offer.
  logic [3:0]     part[$];
  logic           m_hold;
  logic [N*4-1:0] m_word;
  int             m_cnt;
  logic [7:0]     m_seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_hold = 1'b0;
    m_word = '0;
    m_cnt  = 0;
    m_seq  = 8'd0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".outValid"}, 32'(outValid), 32'(m_hold));
    check({tag, ".outSeq"}, 32'(outSeq), 32'(m_seq));
    if (m_hold) begin
      check({tag, ".outWord"}, 32'(outWord), 32'(m_word));
      check({tag, ".outCount"}, 32'(outCount), 32'(m_cnt));
    end
  endtask

  // One clock cycle: drive inputs, check inReady, advance model, check registered outputs.
  task automatic step(input logic v, input logic [3:0] n, input logic f, input logic r);
    logic exp_rdy;
    logic acc;
    inValid  = v;
    inVal    = v ? n : 4'($urandom_range(0, 15));
    flush    = f;
    outReady = r;
    #1;
    exp_rdy = !m_hold || r;
    check("inReady", 32'(inReady), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (m_hold && r) begin
      m_hold = 1'b0;
      m_seq  = m_seq + 8'd1;
    end
    if (acc) part.push_back(n);
    if (part.size() == N || (f && part.size() > 0 && !m_hold)) begin
      for (int k = 0; k < N; k++)
        m_word[4*k +: 4] = (k < part.size()) ? part[k] : PAD;
      m_cnt  = part.size();
      m_hold = 1'b1;
      part.delete();
    end
    @(posedge ck);
    #1;
    check_outputs("cyc");
    @(negedge ck);
  endtask

  initial begin
    arst = 1'b1; inVal = '0; inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
    model_reset();
    #2;
    check("rst.outValid", 32'(outValid), 32'd0);
    check("rst.outWord", 32'(outWord), 32'd0);
    check("rst.outCount", 32'(outCount), 32'd0);
    check("rst.outSeq", 32'(outSeq), 32'd0);
    check("rst.inReady", 32'(inReady), 32'd1);
    @(negedge ck);
    arst = 1'b0;

    // Four nibbles complete a word one edge after the last one.
    step(1, 4'h9, 0, 1); step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h3, 0, 1);
    check("tp1.word", 32'(outWord), 32'h3219);
    check("tp1.count", 32'(outCount), 32'd4);
    step(0, 4'h0, 0, 1);
    check("tp1.seq", 32'(outSeq), 32'd1);

    // Partial word closed by flush; an empty flush emits nothing.
    step(1, 4'hA, 0, 1); step(1, 4'hB, 0, 1); step(0, 4'h0, 1, 0);
    check("tp2.word", 32'(outWord), 32'h99BA);
    check("tp2.count", 32'(outCount), 32'd2);
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 1, 1);
    check("tp2.emptyflush", 32'(outValid), 32'd0);

    // Back-pressure: word holds, no nibble lost, pop with accept starts next word.
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0); step(1, 4'h3, 0, 0); step(1, 4'h4, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'hE, 0, 0);
    check("tp3.held", 32'(outWord), 32'h4321);
    step(1, 4'h5, 0, 1);
    step(1, 4'h6, 0, 1); step(1, 4'h7, 0, 1); step(1, 4'h8, 0, 1);
    check("tp3.word", 32'(outWord), 32'h8765);

    // Continuous stream, no idle cycles between words.
    for (int i = 0; i < 16; i++) step(1, 4'(i), 0, 1);
    check("tp4.last", 32'(outWord), 32'hFEDC);
    step(0, 4'h0, 0, 1);

    // Pop + accept + flush yields a one-nibble padded word.
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0); step(1, 4'h3, 0, 0); step(1, 4'h4, 0, 0);
    step(1, 4'hC, 1, 1);
    check("ppf.word", 32'(outWord), 32'h999C);
    check("ppf.count", 32'(outCount), 32'd1);
    step(0, 4'h0, 0, 1);

    // Asynchronous reset mid-word discards the partial word.
    step(1, 4'h7, 0, 1); step(1, 4'h7, 0, 1); step(1, 4'h7, 0, 1);
    arst = 1'b1;
    #1;
    model_reset();
    check("arst.outValid", 32'(outValid), 32'd0);
    check("arst.outCount", 32'(outCount), 32'd0);
    check("arst.outSeq", 32'(outSeq), 32'd0);
    @(negedge ck);
    arst = 1'b0;
    step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h3, 0, 1); step(1, 4'h4, 0, 1);
    check("arst.clean", 32'(outWord), 32'h4321);

    // Random traffic; long enough to wrap outSeq past 255.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
